// File: rtl/rv32_types_pkg.sv
// rv32 shared pipeline types.
// Buffer bundles, memory opcodes and MEM stage state.
package rv32_types;

  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LH  = 4'd2,
    MEM_LW  = 4'd3,
    MEM_LBU = 4'd4,
    MEM_LHU = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_op_t;

  typedef struct packed {
    logic    register_wb;
    mem_op_t mem_op;
  } control_t;

  typedef struct packed {
    logic [31:0]      instr;
    control_t         control;
    logic [1:0][31:0] data_result;
  } exec_mem_buffer_t;

  typedef struct packed {
    logic [31:0]      instr;
    control_t         control;
    logic [1:0][31:0] data_result;
    logic             mem_misaligned;
  } mem_wb_buffer_t;

  typedef enum logic {
    MEM_IDLE     = 1'b0,
    MEM_WAIT_GNT = 1'b1
  } mem_stage_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } dbus_req_t;

  function automatic logic is_store(mem_op_t op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

endpackage

// File: rtl/rv32_store_align.sv
// Store lane replication, byte strobes and
// alignment check for data memory accesses.
module rv32_store_align
  import rv32_types::*;
(
  input  mem_op_t     mem_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] sdata,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        misaligned
);

  // decode lanes and alignment from opcode and low address bits
  always_comb begin
    wdata      = '0;
    wstrb      = '0;
    misaligned = 1'b0;
    unique case (mem_op)
      MEM_SB: begin
        wdata = {4{sdata[7:0]}};
        wstrb = 4'b0001 << addr_lo;
      end
      MEM_SH: begin
        wdata      = {2{sdata[15:0]}};
        wstrb      = 4'b0011 << {addr_lo[1], 1'b0};
        misaligned = addr_lo[0];
      end
      MEM_SW: begin
        wdata      = sdata;
        wstrb      = 4'b1111;
        misaligned = |addr_lo;
      end
      MEM_LH, MEM_LHU: misaligned = addr_lo[0];
      MEM_LW:          misaligned = |addr_lo;
      default: ;
    endcase
  end

endmodule

// File: rtl/rv32_mem_stage.sv
// rv32 MEM stage: data bus requests, grant wait,
// misalignment trap marking and MEM/WB register.
module rv32_mem_stage
  import rv32_types::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  exec_mem_buffer_t exec_mem_buff,
  input  logic             mem_flush,
  output mem_wb_buffer_t   mem_wb_buff,
  output logic             mem_stall,
  output logic             mem_misaligned,
  output logic [31:0]      stall_cycles,
  output logic             dbus_req,
  output logic [31:0]      dbus_addr,
  output logic             dbus_we,
  output logic [3:0]       dbus_wstrb,
  output logic [31:0]      dbus_wdata,
  input  logic             dbus_gnt
);

  mem_stage_state_t state_q, state_d;
  dbus_req_t        out_q, dec, bus;
  logic             kill_q;
  logic [31:0]      stall_cnt_q;
  logic             mis_q;
  mem_wb_buffer_t   wb_q, wb_d;
  logic             mis_d;

  logic [31:0] ea, sdata, al_wdata;
  logic [3:0]  al_wstrb;
  logic        mis, access, bubble;
  mem_op_t     op;

  assign ea    = exec_mem_buff.data_result[0];
  assign sdata = exec_mem_buff.data_result[1];
  assign op    = exec_mem_buff.control.mem_op;

  rv32_store_align u_align (
    .mem_op     (op),
    .addr_lo    (ea[1:0]),
    .sdata      (sdata),
    .wdata      (al_wdata),
    .wstrb      (al_wstrb),
    .misaligned (mis)
  );

  assign access = (op != MEM_NOP) && !mis;

  // request as decoded from the instruction now in MEM
  always_comb begin
    dec       = '0;
    dec.addr  = {ea[31:2], 2'b00};
    dec.we    = is_store(op);
    dec.wstrb = dec.we ? al_wstrb : 4'b0000;
    dec.wdata = al_wdata;
  end

  // next state, bus drive and stall
  always_comb begin
    state_d   = state_q;
    bus       = '0;
    dbus_req  = 1'b0;
    mem_stall = 1'b0;
    unique case (state_q)
      MEM_IDLE: begin
        dbus_req  = access && !mem_flush;
        bus       = dbus_req ? dec : '0;
        mem_stall = dbus_req && !dbus_gnt;
        if (mem_stall) state_d = MEM_WAIT_GNT;
      end
      MEM_WAIT_GNT: begin
        dbus_req  = 1'b1;
        bus       = out_q;
        mem_stall = !dbus_gnt;
        if (dbus_gnt) state_d = MEM_IDLE;
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  assign dbus_addr  = bus.addr;
  assign dbus_we    = bus.we;
  assign dbus_wstrb = bus.wstrb;
  assign dbus_wdata = bus.wdata;

  // MEM/WB entry: bubble, trap marker or pass-through
  always_comb begin
    bubble = mem_stall
           || (state_q == MEM_IDLE && mem_flush)
           || (state_q == MEM_WAIT_GNT && dbus_gnt
               && (kill_q || mem_flush));
    wb_d  = '0;
    mis_d = 1'b0;
    if (!bubble) begin
      wb_d.instr          = exec_mem_buff.instr;
      wb_d.control        = exec_mem_buff.control;
      wb_d.data_result[0] = ea;
      wb_d.data_result[1] = ea;
      if (mis) begin
        wb_d.control.register_wb = 1'b0;
        wb_d.control.mem_op      = MEM_NOP;
        wb_d.mem_misaligned      = 1'b1;
        mis_d                    = 1'b1;
      end
    end
  end

  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= MEM_IDLE;
    else         state_q <= state_d;
  end

  // outstanding request and sticky kill
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_q  <= '0;
      kill_q <= 1'b0;
    end else if (state_q == MEM_IDLE && mem_stall) begin
      out_q  <= dec;
      kill_q <= 1'b0;
    end else if (state_q == MEM_WAIT_GNT && mem_flush) begin
      kill_q <= 1'b1;
    end
  end

  // MEM/WB register and trap flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wb_q  <= '0;
      mis_q <= 1'b0;
    end else begin
      wb_q  <= wb_d;
      mis_q <= mis_d;
    end
  end

  // stall cycle counter, wraps naturally
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)        stall_cnt_q <= '0;
    else if (mem_stall) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign mem_wb_buff    = wb_q;
  assign mem_misaligned = mis_q;
  assign stall_cycles   = stall_cnt_q;

endmodule

// File: tb/tb_rv32_mem_stage.sv
// Directed bench for rv32_mem_stage.
// Inputs change 1ns after posedge; outputs checked then.
module tb_rv32_mem_stage;
  import rv32_types::*;

  logic             clk = 1'b0;
  logic             resetn;
  exec_mem_buffer_t exec_mem_buff;
  logic             mem_flush;
  mem_wb_buffer_t   mem_wb_buff;
  logic             mem_stall;
  logic             mem_misaligned;
  logic [31:0]      stall_cycles;
  logic             dbus_req;
  logic [31:0]      dbus_addr;
  logic             dbus_we;
  logic [3:0]       dbus_wstrb;
  logic [31:0]      dbus_wdata;
  logic             dbus_gnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rv32_mem_stage dut (
    .clk            (clk),
    .resetn         (resetn),
    .exec_mem_buff  (exec_mem_buff),
    .mem_flush      (mem_flush),
    .mem_wb_buff    (mem_wb_buff),
    .mem_stall      (mem_stall),
    .mem_misaligned (mem_misaligned),
    .stall_cycles   (stall_cycles),
    .dbus_req       (dbus_req),
    .dbus_addr      (dbus_addr),
    .dbus_we        (dbus_we),
    .dbus_wstrb     (dbus_wstrb),
    .dbus_wdata     (dbus_wdata),
    .dbus_gnt       (dbus_gnt)
  );

  function automatic exec_mem_buffer_t mk(
    input logic [31:0] instr, input logic rwb,
    input mem_op_t op, input logic [31:0] a,
    input logic [31:0] d);
    exec_mem_buffer_t e;
    e = '0;
    e.instr = instr;
    e.control.register_wb = rwb;
    e.control.mem_op = op;
    e.data_result[0] = a;
    e.data_result[1] = d;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    exec_mem_buff = '0;
    mem_flush = 1'b0;
    dbus_gnt = 1'b0;
    #12;
    n_checks++;
    if (mem_wb_buff !== '0) begin n_fail++;
      $display("FAIL reset_wb got %h want 0", mem_wb_buff); end
    n_checks++;
    if ({mem_misaligned, mem_stall, dbus_req} !== 3'b000) begin n_fail++;
      $display("FAIL reset_flags got %b want 000",
               {mem_misaligned, mem_stall, dbus_req}); end
    n_checks++;
    if (stall_cycles !== 32'd0) begin n_fail++;
      $display("FAIL reset_cnt got %0d want 0", stall_cycles); end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_store_byte();
    exec_mem_buff = mk(32'h00508023, 1'b0, MEM_SB, 32'h1003, 32'hAB);
    dbus_gnt = 1'b1;
    #1;
    n_checks++;
    if ({dbus_req, dbus_we, mem_stall} !== 3'b110) begin n_fail++;
      $display("FAIL sb_req got %b want 110", {dbus_req, dbus_we, mem_stall}); end
    n_checks++;
    if (dbus_addr !== 32'h1000) begin n_fail++;
      $display("FAIL sb_addr got %h want 00001000", dbus_addr); end
    n_checks++;
    if (dbus_wstrb !== 4'b1000) begin n_fail++;
      $display("FAIL sb_wstrb got %b want 1000", dbus_wstrb); end
    n_checks++;
    if (dbus_wdata !== 32'hABABABAB) begin n_fail++;
      $display("FAIL sb_wdata got %h want abababab", dbus_wdata); end
    step();
    exec_mem_buff = '0;
    n_checks++;
    if (mem_wb_buff.control.mem_op !== MEM_SB ||
        mem_wb_buff.data_result[1] !== 32'h1003) begin n_fail++;
      $display("FAIL sb_wb got op %0d ea %h want 6 00001003",
               mem_wb_buff.control.mem_op, mem_wb_buff.data_result[1]); end
    #1;
    n_checks++;
    if (dbus_req !== 1'b0) begin n_fail++;
      $display("FAIL sb_one_cycle got req %b want 0", dbus_req); end
  endtask

  task automatic test_load_wait();
    exec_mem_buff = mk(32'h00002283, 1'b1, MEM_LW, 32'h2000, 32'h0);
    dbus_gnt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if ({mem_stall, dbus_req, dbus_we} !== 3'b110 ||
          dbus_addr !== 32'h2000 || dbus_wstrb !== 4'b0000) begin n_fail++;
        $display("FAIL lw_wait%0d got st/req/we %b addr %h strb %b want 110 00002000 0000",
                 c, {mem_stall, dbus_req, dbus_we}, dbus_addr, dbus_wstrb); end
      step();
      n_checks++;
      if (mem_wb_buff !== '0) begin n_fail++;
        $display("FAIL lw_bubble%0d got %h want 0", c, mem_wb_buff); end
    end
    dbus_gnt = 1'b1;
    #1;
    n_checks++;
    if ({mem_stall, dbus_req} !== 2'b01) begin n_fail++;
      $display("FAIL lw_gnt got st/req %b want 01", {mem_stall, dbus_req}); end
    step();
    exec_mem_buff = '0;
    dbus_gnt = 1'b0;
    n_checks++;
    if (mem_wb_buff.control.mem_op !== MEM_LW ||
        mem_wb_buff.control.register_wb !== 1'b1 ||
        mem_wb_buff.instr !== 32'h00002283) begin n_fail++;
      $display("FAIL lw_wb got op %0d rwb %b instr %h want 3 1 00002283",
               mem_wb_buff.control.mem_op, mem_wb_buff.control.register_wb,
               mem_wb_buff.instr); end
    n_checks++;
    if (stall_cycles !== 32'd3) begin n_fail++;
      $display("FAIL lw_cnt got %0d want 3", stall_cycles); end
  endtask

  task automatic test_misaligned();
    exec_mem_buff = mk(32'h00001283, 1'b1, MEM_LH, 32'h2001, 32'h0);
    dbus_gnt = 1'b1;
    #1;
    n_checks++;
    if ({dbus_req, mem_stall} !== 2'b00) begin n_fail++;
      $display("FAIL mis_noreq got req/st %b want 00", {dbus_req, mem_stall}); end
    step();
    exec_mem_buff = '0;
    n_checks++;
    if (mem_misaligned !== 1'b1 || mem_wb_buff.control.register_wb !== 1'b0 ||
        mem_wb_buff.control.mem_op !== MEM_NOP ||
        mem_wb_buff.mem_misaligned !== 1'b1) begin n_fail++;
      $display("FAIL mis_wb got mis %b rwb %b op %0d want 1 0 0",
               mem_misaligned, mem_wb_buff.control.register_wb,
               mem_wb_buff.control.mem_op); end
    step();
    n_checks++;
    if (mem_misaligned !== 1'b0) begin n_fail++;
      $display("FAIL mis_clear got %b want 0", mem_misaligned); end
  endtask

  task automatic test_flush_wait();
    exec_mem_buff = mk(32'h0062a023, 1'b0, MEM_SW, 32'h4000, 32'hDEADBEEF);
    dbus_gnt = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      mem_flush = (c == 2);
      dbus_gnt  = (c == 4);
      #1;
      n_checks++;
      if (dbus_req !== 1'b1 || dbus_addr !== 32'h4000 ||
          dbus_wdata !== 32'hDEADBEEF || dbus_wstrb !== 4'b1111 ||
          mem_stall !== (c != 4)) begin n_fail++;
        $display("FAIL sw_hold%0d got req %b addr %h wd %h strb %b st %b",
                 c, dbus_req, dbus_addr, dbus_wdata, dbus_wstrb, mem_stall); end
      step();
    end
    mem_flush = 1'b0;
    dbus_gnt = 1'b0;
    n_checks++;
    if (mem_wb_buff !== '0) begin n_fail++;
      $display("FAIL sw_killed got %h want 0", mem_wb_buff); end
    n_checks++;
    if (stall_cycles !== 32'd6) begin n_fail++;
      $display("FAIL sw_cnt got %0d want 6", stall_cycles); end
    mem_flush = 1'b1;
    dbus_gnt = 1'b1;
    #1;
    n_checks++;
    if ({dbus_req, mem_stall} !== 2'b00) begin n_fail++;
      $display("FAIL idle_flush got req/st %b want 00", {dbus_req, mem_stall}); end
    step();
    n_checks++;
    if (mem_wb_buff !== '0) begin n_fail++;
      $display("FAIL idle_flush_wb got %h want 0", mem_wb_buff); end
    mem_flush = 1'b0;
    exec_mem_buff = '0;
    dbus_gnt = 1'b0;
  endtask

  task automatic test_back_to_back();
    dbus_gnt = 1'b1;
    exec_mem_buff = mk(32'h00b50533, 1'b1, MEM_NOP, 32'h55, 32'h7);
    #1;
    n_checks++;
    if ({dbus_req, mem_stall} !== 2'b00) begin n_fail++;
      $display("FAIL add_nobus got req/st %b want 00", {dbus_req, mem_stall}); end
    step();
    exec_mem_buff = mk(32'h00629123, 1'b0, MEM_SH, 32'h3002, 32'h1234);
    n_checks++;
    if (mem_wb_buff.data_result[0] !== 32'h55 ||
        mem_wb_buff.control.register_wb !== 1'b1) begin n_fail++;
      $display("FAIL add_wb got res %h rwb %b want 00000055 1",
               mem_wb_buff.data_result[0], mem_wb_buff.control.register_wb); end
    #1;
    n_checks++;
    if (dbus_req !== 1'b1 || dbus_addr !== 32'h3000 ||
        dbus_wstrb !== 4'b1100 || dbus_wdata !== 32'h12341234) begin n_fail++;
      $display("FAIL sh_bus got req %b addr %h strb %b wd %h want 1 00003000 1100 12341234",
               dbus_req, dbus_addr, dbus_wstrb, dbus_wdata); end
    step();
    exec_mem_buff = mk(32'h00028283, 1'b1, MEM_LB, 32'h3005, 32'h0);
    n_checks++;
    if (mem_wb_buff.control.mem_op !== MEM_SH) begin n_fail++;
      $display("FAIL sh_wb got op %0d want 7", mem_wb_buff.control.mem_op); end
    #1;
    n_checks++;
    if (dbus_req !== 1'b1 || dbus_we !== 1'b0 ||
        dbus_wstrb !== 4'b0000 || dbus_addr !== 32'h3004) begin n_fail++;
      $display("FAIL lb_bus got req %b we %b strb %b addr %h want 1 0 0000 00003004",
               dbus_req, dbus_we, dbus_wstrb, dbus_addr); end
    step();
    exec_mem_buff = '0;
    n_checks++;
    if (mem_wb_buff.control.mem_op !== MEM_LB ||
        mem_wb_buff.data_result[1] !== 32'h3005) begin n_fail++;
      $display("FAIL lb_wb got op %0d ea %h want 1 00003005",
               mem_wb_buff.control.mem_op, mem_wb_buff.data_result[1]); end
    dbus_gnt = 1'b0;
  endtask

  task automatic test_reset_wait();
    exec_mem_buff = mk(32'h00002303, 1'b1, MEM_LW, 32'h5000, 32'h0);
    dbus_gnt = 1'b0;
    step();
    resetn = 1'b0;
    exec_mem_buff = '0;
    #1;
    n_checks++;
    if ({dbus_req, mem_stall, mem_misaligned} !== 3'b000 ||
        mem_wb_buff !== '0 || stall_cycles !== 32'd0) begin n_fail++;
      $display("FAIL rst_wait got req/st/mis %b wb %h cnt %0d want 000 0 0",
               {dbus_req, mem_stall, mem_misaligned}, mem_wb_buff, stall_cycles); end
    #3;
    resetn = 1'b1;
    step();
    n_checks++;
    if (dbus_req !== 1'b0) begin n_fail++;
      $display("FAIL rst_dropped got req %b want 0", dbus_req); end
  endtask

  task automatic test_wrap();
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    #1;
    n_checks++;
    if (stall_cycles !== 32'hFFFF_FFFF) begin n_fail++;
      $display("FAIL wrap_preload got %h want ffffffff", stall_cycles); end
    exec_mem_buff = mk(32'h00002383, 1'b1, MEM_LW, 32'h6000, 32'h0);
    dbus_gnt = 1'b0;
    step();
    n_checks++;
    if (stall_cycles !== 32'd0) begin n_fail++;
      $display("FAIL wrap got %h want 0", stall_cycles); end
    dbus_gnt = 1'b1;
    step();
    exec_mem_buff = '0;
    dbus_gnt = 1'b0;
    n_checks++;
    if (mem_wb_buff.control.mem_op !== MEM_LW || stall_cycles !== 32'd0) begin
      n_fail++;
      $display("FAIL wrap_done got op %0d cnt %0d want 3 0",
               mem_wb_buff.control.mem_op, stall_cycles); end
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_load_wait();
    test_misaligned();
    test_flush_wait();
    test_back_to_back();
    test_reset_wait();
    test_wrap();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
